// File: rtl/image_source.sv
// Video-bus transmitter: streams one stored frame per start pulse from a
// synchronous pixel memory onto the 27-bit {frame_end, vsync, de, RGB} bus.
module image_source #(
    parameter int VS_LEN  = 2,
    parameter int H_BLANK = 4,
    parameter int AW      = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [11:0]   Hsize,
    input  logic [10:0]   Vsize,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [23:0]   rd_data,
    output logic [26:0]   DPo,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_HBLANK,
        S_ACTIVE,
        S_TAIL,
        S_END
    } state_t;

    localparam logic [11:0] VS_LAST = 12'(VS_LEN - 1);
    localparam logic [11:0] HB_LAST = 12'(H_BLANK - 1);
    // First HBLANK count whose read lands on the first DE cycle of the line.
    localparam logic [11:0] RD_LEAD = 12'(H_BLANK - 2);

    state_t      state, state_n;
    logic [11:0] cnt, cnt_n;
    logic [10:0] line, line_n;
    logic [11:0] h_q;
    logic [10:0] v_q;
    logic        accept;
    logic        rd_en_n;

    assign accept = (state == S_IDLE) && start && (Hsize != '0) && (Vsize != '0);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n = state;
        cnt_n   = cnt;
        line_n  = line;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_VSYNC;
                    cnt_n   = '0;
                    line_n  = '0;
                end
            end
            S_VSYNC: begin
                cnt_n = cnt + 12'd1;
                if (cnt == VS_LAST) begin
                    state_n = S_HBLANK;
                    cnt_n   = '0;
                end
            end
            S_HBLANK: begin
                cnt_n = cnt + 12'd1;
                if (cnt == HB_LAST) begin
                    state_n = S_ACTIVE;
                    cnt_n   = '0;
                end
            end
            S_ACTIVE: begin
                cnt_n = cnt + 12'd1;
                if (cnt == h_q - 12'd1) begin
                    cnt_n = '0;
                    if (line == v_q - 11'd1) begin
                        state_n = S_TAIL;
                    end else begin
                        state_n = S_HBLANK;
                        line_n  = line + 11'd1;
                    end
                end
            end
            S_TAIL: begin
                cnt_n = cnt + 12'd1;
                if (cnt == HB_LAST) begin
                    state_n = S_END;
                    cnt_n   = '0;
                end
            end
            S_END:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Reads run two cycles ahead of DE: pixels 0/1 in the last two HBLANK
    // cycles, pixel x+2 during ACTIVE cycle x.
    always_comb begin
        rd_en_n = 1'b0;
        if (state_n == S_HBLANK && cnt_n >= RD_LEAD)
            rd_en_n = (cnt_n - RD_LEAD) < h_q;
        else if (state_n == S_ACTIVE)
            rd_en_n = ({1'b0, cnt_n} + 13'd2) < {1'b0, h_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            line  <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_n;
            cnt   <= cnt_n;
            line  <= line_n;
            if (accept) begin
                h_q <= Hsize;
                v_q <= Vsize;
            end
        end
    end

    // Outputs are registered from the next state, so they line up with the
    // state they describe instead of lagging it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DPo     <= '0;
            busy    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            DPo[26]   <= (state_n == S_END);
            DPo[25]   <= (state_n == S_VSYNC);
            DPo[24]   <= (state_n == S_ACTIVE);
            DPo[23:0] <= (state_n == S_ACTIVE) ? rd_data : 24'd0;
            busy      <= (state_n != S_IDLE);
            rd_en     <= rd_en_n;
            if (accept)
                rd_addr <= '0;
            else if (rd_en)
                rd_addr <= rd_addr + AW'(1);
        end
    end

endmodule

// File: tb/tb_image_source.sv
// Self-checking bench for image_source: table-driven frames, hand-written
// corner sequences and randomized frames against a cycle-formula model.
module tb_image_source;

    localparam int VS_LEN  = 2;
    localparam int H_BLANK = 4;
    localparam int AW      = 23;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [11:0]   Hsize;
    logic [10:0]   Vsize;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data = '0;
    logic [26:0]   DPo;
    logic          busy;

    image_source #(.VS_LEN(VS_LEN), .H_BLANK(H_BLANK), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .Hsize   (Hsize),
        .Vsize   (Vsize),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .DPo     (DPo),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [0:1023];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[9:0]];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        busy;
        logic        rd_en;
        logic [22:0] addr;
        logic [26:0] dpo;
    } exp_t;

    typedef struct {
        int h;
        int v;
        int exp_end;
        int exp_de;
    } vec_t;

    logic [23:0] cap_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for cycle t after the start cycle (t=0), derived from
    // the frame layout: VS_LEN vsync cycles, then V lines of (H_BLANK + H),
    // then H_BLANK tail cycles and a single frame_end cycle.
    function automatic exp_t model(input int t, input int h, input int v);
        exp_t e;
        int l    = H_BLANK + h;
        int tend = 1 + VS_LEN + v * l + H_BLANK;
        int u;
        e.busy  = (t >= 1) && (t <= tend);
        e.rd_en = 1'b0;
        e.addr  = '0;
        e.dpo   = '0;
        e.dpo[25] = (t >= 1) && (t <= VS_LEN);
        e.dpo[26] = (t == tend);
        u = t - 1 - VS_LEN;
        if (u >= 0 && u < v * l && (u % l) >= H_BLANK) begin
            e.dpo[24]   = 1'b1;
            e.dpo[23:0] = mem[10'((u / l) * h + (u % l) - H_BLANK)];
        end
        u = t + 2 - 1 - VS_LEN;
        if (u >= 0 && u < v * l && (u % l) >= H_BLANK) begin
            e.rd_en = 1'b1;
            e.addr  = 23'((u / l) * h + (u % l) - H_BLANK);
        end
        return e;
    endfunction

    // Drives start in the current cycle and follows the whole frame up to the
    // first idle cycle, comparing every output each cycle. mask[t] pulses start
    // during cycle t; scramble changes the size inputs once the frame is running.
    task automatic run_frame(input int h, input int v, input logic [127:0] mask,
                             input logic scramble,
                             output int fe_cycle, output int fe_cnt, output int de_cnt);
        exp_t e;
        int tend = 1 + VS_LEN + v * (H_BLANK + h) + H_BLANK;
        Hsize = 12'(h);
        Vsize = 11'(v);
        start = 1'b1;
        fe_cycle = -1;
        fe_cnt   = 0;
        de_cnt   = 0;
        cap_q.delete();
        for (int t = 1; t <= tend + 1; t++) begin
            tick();
            start = (t <= tend) ? mask[t] : 1'b0;
            if (scramble && t == 1) begin
                Hsize = 12'($urandom_range(0, 4095));
                Vsize = 11'($urandom_range(0, 2047));
            end
            e = model(t, h, v);
            check($sformatf("dpo %0dx%0d t=%0d", h, v, t), 64'(DPo), 64'(e.dpo));
            check($sformatf("busy %0dx%0d t=%0d", h, v, t), 64'(busy), 64'(e.busy));
            check($sformatf("rd_en %0dx%0d t=%0d", h, v, t), 64'(rd_en), 64'(e.rd_en));
            if (e.rd_en)
                check($sformatf("rd_addr %0dx%0d t=%0d", h, v, t), 64'(rd_addr), 64'(e.addr));
            if (DPo[24]) begin
                de_cnt++;
                cap_q.push_back(DPo[23:0]);
            end
            if (DPo[26]) begin
                fe_cnt++;
                if (fe_cycle < 0) fe_cycle = t;
            end
        end
        start = 1'b0;
    endtask

    task automatic zero_size(input int h, input int v);
        logic any_busy, any_rd;
        logic [26:0] any_dpo;
        any_busy = 1'b0;
        any_rd   = 1'b0;
        any_dpo  = '0;
        Hsize = 12'(h);
        Vsize = 11'(v);
        start = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            start = 1'b0;
            any_busy |= busy;
            any_rd   |= rd_en;
            any_dpo  |= DPo;
        end
        check($sformatf("zero %0dx%0d busy", h, v), 64'(any_busy), 64'(0));
        check($sformatf("zero %0dx%0d rd_en", h, v), 64'(any_rd), 64'(0));
        check($sformatf("zero %0dx%0d dpo", h, v), 64'(any_dpo), 64'(0));
    endtask

    initial begin
        vec_t tbl[5];
        logic [23:0] first_q[$];
        logic [127:0] mask;
        int fe_cycle, fe_cnt, de_cnt;
        int h, v, tend;

        tbl[0] = '{h: 4, v: 2, exp_end: 23, exp_de: 8};
        tbl[1] = '{h: 1, v: 3, exp_end: 22, exp_de: 3};
        tbl[2] = '{h: 3, v: 1, exp_end: 14, exp_de: 3};
        tbl[3] = '{h: 1, v: 1, exp_end: 12, exp_de: 1};
        tbl[4] = '{h: 5, v: 3, exp_end: 34, exp_de: 15};

        for (int i = 0; i < 1024; i++) mem[i] = 24'(24'h010101 * i);

        rst_n = 1'b0;
        start = 1'b0;
        Hsize = '0;
        Vsize = '0;
        repeat (3) tick();
        check("reset dpo", 64'(DPo), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset rd_en", 64'(rd_en), 64'(0));
        check("reset rd_addr", 64'(rd_addr), 64'(0));
        rst_n = 1'b1;
        tick();

        // Table-driven frames, each checked cycle by cycle and by summary.
        foreach (tbl[i]) begin
            run_frame(tbl[i].h, tbl[i].v, '0, 1'b0, fe_cycle, fe_cnt, de_cnt);
            check($sformatf("tbl%0d frame_end cycle", i), 64'(fe_cycle), 64'(tbl[i].exp_end));
            check($sformatf("tbl%0d frame_end count", i), 64'(fe_cnt), 64'(1));
            check($sformatf("tbl%0d de count", i), 64'(de_cnt), 64'(tbl[i].exp_de));
            repeat (2) tick();
        end

        // Back-to-back: second start on the first idle cycle after END.
        run_frame(4, 2, '0, 1'b0, fe_cycle, fe_cnt, de_cnt);
        first_q = cap_q;
        run_frame(4, 2, '0, 1'b0, fe_cycle, fe_cnt, de_cnt);
        check("b2b frame_end cycle", 64'(fe_cycle), 64'(23));
        check("b2b image size", 64'(cap_q.size()), 64'(first_q.size()));
        check("b2b image equal", 64'(cap_q == first_q), 64'(1));
        repeat (2) tick();

        // Start pulses while busy, including the END cycle, must be ignored.
        mask = '0;
        mask[3] = 1'b1;
        mask[10] = 1'b1;
        mask[23] = 1'b1;
        run_frame(4, 2, mask, 1'b1, fe_cycle, fe_cnt, de_cnt);
        check("busy-start frame_end count", 64'(fe_cnt), 64'(1));
        check("busy-start frame_end cycle", 64'(fe_cycle), 64'(23));
        repeat (3) tick();
        check("busy-start no restart", 64'(busy), 64'(0));

        zero_size(0, 2);
        zero_size(4, 0);

        // Reset in the middle of the first line.
        Hsize = 12'd4;
        Vsize = 11'd2;
        start = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            start = 1'b0;
        end
        check("pre-reset de", 64'(DPo[24]), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid reset dpo", 64'(DPo), 64'(0));
        check("mid reset busy", 64'(busy), 64'(0));
        check("mid reset rd_addr", 64'(rd_addr), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        fe_cnt = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (DPo[26] || busy) fe_cnt++;
        end
        check("post reset idle", 64'(fe_cnt), 64'(0));
        run_frame(4, 2, '0, 1'b0, fe_cycle, fe_cnt, de_cnt);
        check("post reset frame_end cycle", 64'(fe_cycle), 64'(23));
        check("post reset de count", 64'(de_cnt), 64'(8));

        // Randomized frames and memory contents, with stray starts while busy.
        for (int i = 0; i < 1024; i++) mem[i] = 24'($urandom);
        for (int n = 0; n < 12; n++) begin
            h = $urandom_range(1, 8);
            v = $urandom_range(1, 5);
            tend = 1 + VS_LEN + v * (H_BLANK + h) + H_BLANK;
            mask = '0;
            repeat (3) mask[$urandom_range(1, tend)] = 1'b1;
            run_frame(h, v, mask, 1'b1, fe_cycle, fe_cnt, de_cnt);
            check($sformatf("rand%0d frame_end count", n), 64'(fe_cnt), 64'(1));
            check($sformatf("rand%0d de count", n), 64'(de_cnt), 64'(h * v));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
